// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state codes,
// opcodes, alu_op codes, mux encodings and the decoded control word.
package mips_multicycle_control_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 4;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_IMM_WB    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 4'b0110;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // ir_write and pc_write in FETCH are still qualified by mem_ready at the top.
  typedef struct packed {
    logic               mem_req;
    logic               mem_we;
    logic               iord;
    logic               ir_write;
    logic               pc_write;
    logic               pc_write_cond;
    logic               branch_ne;
    logic [1:0]         pc_src;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Memory request/ready handshake between the control FSM and memory.
interface mips_multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mips_multicycle_control_decode.sv
// Control-word ROM: maps the current state (and opcode where needed) to
// the raw datapath controls.
module mips_multicycle_control_decode
  import mips_multicycle_control_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = PC_SRC_ALU;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_SRC_ALUOUT;
        ctrl.branch_ne     = opcode[0];
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_JUMP;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_IMM_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: state register, next-state
// logic and the input-dependent gating of ir_write, pc_en and illegal.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_W-1:0]      opcode,
  input  logic                 zero,
  mips_multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_en,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic [3:0]           state,
  output logic                 illegal
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  mips_multicycle_control_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_R:                              state_d = S_EXEC_R;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem.mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem.mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_IMM_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // The FETCH loads only land once memory delivers; reset masks them outright.
  assign ir_write = rst_n & ctrl.ir_write & mem.mem_ready;
  assign pc_en    = rst_n & ((ctrl.pc_write & (~ctrl.ir_write | mem.mem_ready)) |
                             (ctrl.pc_write_cond & (zero ^ ctrl.branch_ne)));
  assign illegal  = (state_q == S_DECODE) & ~op_supported(opcode);

  assign mem.mem_req = ctrl.mem_req;
  assign mem.mem_we  = ctrl.mem_we;
  assign mem.iord    = ctrl.iord;
  assign pc_src      = ctrl.pc_src;
  assign reg_write   = ctrl.reg_write;
  assign reg_dst     = ctrl.reg_dst;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_op      = ctrl.alu_op;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: a state-path reference model
// pushes per-cycle expectations; a negedge monitor pops and compares them.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       src_a;
    logic [1:0] src_b;
    logic [3:0] alu_op;
    logic       illegal;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       ir_write, pc_en, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op, state;

  int   compared   = 0;
  int   mismatched = 0;
  obs_t sb[$];

  logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

  mips_multicycle_control_if mem_if ();

  mips_multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mem_if),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .state      (state),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic obs_t exp_out(input int st, input logic [5:0] op, input logic z,
                                   input logic mr, input logic in_rst);
    obs_t e = '0;
    e.st = 4'(st);
    case (st)
      0:  begin e.mem_req = 1; e.src_b = 2'b01; e.ir_write = mr & ~in_rst; e.pc_en = mr & ~in_rst; end
      1:  begin e.src_b = 2'b11; e.illegal = ~is_legal(op); end
      2:  begin e.src_a = 1; e.src_b = 2'b10; end
      3:  begin e.mem_req = 1; e.iord = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      5:  begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; end
      6:  begin e.src_a = 1; e.alu_op = 4'b0010; end
      7:  begin e.reg_write = 1; e.reg_dst = 1; end
      8:  begin e.src_a = 1; e.alu_op = 4'b0001; e.pc_src = 2'b01; e.pc_en = z ^ op[0]; end
      9:  begin e.pc_en = 1; e.pc_src = 2'b10; end
      10: begin
        e.src_a = 1; e.src_b = 2'b10;
        if (op == 6'b001100)      e.alu_op = 4'b0011;
        else if (op == 6'b001101) e.alu_op = 4'b0101;
        else if (op == 6'b001010) e.alu_op = 4'b0110;
      end
      11: e.reg_write = 1;
      default: ;
    endcase
    return e;
  endfunction

  // States visited after DECODE for each instruction class.
  task automatic path_for(input logic [5:0] op, output int p[$]);
    p = {};
    case (op)
      6'b000000:                                 p = {6, 7};
      6'b100011:                                 p = {2, 3, 4};
      6'b101011:                                 p = {2, 5};
      6'b000100, 6'b000101:                      p = {8};
      6'b000010:                                 p = {9};
      6'b001000, 6'b001100, 6'b001101, 6'b001010: p = {10, 11};
      default:                                   p = {};
    endcase
  endtask

  task automatic apply_stimulus(input int st, input logic [5:0] op, input logic mr, input int zsel);
    opcode           = op;
    mem_if.mem_ready = mr;
    zero             = (zsel < 0) ? 1'($urandom) : 1'(zsel);
    sb.push_back(exp_out(st, op, zero, mr, ~rst_n));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int waits, input int zsel);
    int seq[$];
    int n;
    path_for(op, seq);
    seq.push_front(1);
    seq.push_front(0);
    foreach (seq[i]) begin
      if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
        if (waits < 0)        n = $urandom_range(0, 2);
        else if (seq[i] == 0) n = 0;
        else                  n = waits;
        repeat (n) apply_stimulus(seq[i], op, 1'b0, zsel);
        apply_stimulus(seq[i], op, 1'b1, zsel);
      end else begin
        apply_stimulus(seq[i], op, 1'($urandom), zsel);
      end
    end
  endtask

  task automatic sw_with_reset();
    apply_stimulus(0, 6'b101011, 1'b1, -1);
    apply_stimulus(1, 6'b101011, 1'b0, -1);
    apply_stimulus(2, 6'b101011, 1'b0, -1);
    apply_stimulus(5, 6'b101011, 1'b0, -1);
    mem_if.mem_ready = 1'b0;
    sb.push_back(exp_out(0, 6'b101011, zero, 1'b0, 1'b1));
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) apply_stimulus(0, 6'b101011, 1'b1, -1);
    rst_n = 1'b1;
  endtask

  task automatic check_output(input obs_t act, input obs_t e);
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("[TB] FAIL state%0d_outputs t=%0t: got %h, required %h", e.st, $time, act, e);
    end
  endtask

  initial begin
    obs_t act, e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {state, mem_if.mem_req, mem_if.mem_we, mem_if.iord, ir_write, pc_en, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};
        check_output(act, e);
      end
    end
  end

  initial begin
    #1_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] op;
    rst_n            = 1'b0;
    opcode           = '0;
    zero             = 1'b0;
    mem_if.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) apply_stimulus(0, 6'b000000, 1'($urandom), -1);
    rst_n = 1'b1;

    run_instr(6'b000000, 0, -1);
    run_instr(6'b100011, 2, -1);
    run_instr(6'b000100, 0, 1);
    run_instr(6'b000101, 0, 1);
    run_instr(6'b000101, 0, 0);
    run_instr(6'b001101, 0, -1);
    run_instr(6'b001010, 0, -1);
    run_instr(6'b000010, 0, -1);
    run_instr(6'b111111, 0, -1);
    sw_with_reset();
    run_instr(6'b000000, 0, -1);

    repeat (250) begin
      if ($urandom_range(0, 11) < 10) op = legal_ops[$urandom_range(0, 9)];
      else                            op = 6'($urandom);
      run_instr(op, -1, -1);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
